// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared definitions for the two-master IO bus arbiter.
//   - arb_state_e            : arbiter FSM states
//   - TIMEOUT_CYCLES_DEFAULT : default slave-acknowledge timeout in cycles
//   - ERR_READ_DATA_DEFAULT  : default data returned on a timed-out read
package io_arb_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam logic [15:0] ERR_READ_DATA_DEFAULT  = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/io_arb_rr_pick.sv
// io_arb_rr_pick: combinational round-robin winner select for two masters.
//   req[1:0]    in  request lines (bit i = master i)
//   last_grant  in  master granted most recently
//   valid       out at least one request is present
//   winner      out selected master (meaningful only when valid)
module io_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = last_grant;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      // Tie: hand the bus to whichever master did not have it last.
      2'b11:   winner = ~last_grant;
      default: winner = last_grant;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: arbitrates two masters onto one shared IO bus.
// Every transaction runs IDLE -> BUS -> RESP. The winning master's fields are
// latched in IDLE, held on io_* during BUS until io_acknowledge or timeout,
// and RESP returns a one-cycle acknowledge (plus read data) to that master.
// Ports:
//   clk_clk, reset_reset (sync, active high)
//   m0_*/m1_*            : master request side (enable, address, rw, byte
//                          enable, write data in; acknowledge, read data out)
//   io_*                 : shared bus out; io_acknowledge/io_read_data in
//   err_clear / err_timeout : sticky timeout flag and its clear
//   grant_id             : owner of the current or most recent transaction
// All outputs are registered.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [15:0] ERR_READ_DATA  = ERR_READ_DATA_DEFAULT
) (
  input  logic        clk_clk,
  input  logic        reset_reset,

  input  logic        m0_bus_enable,
  input  logic [15:0] m0_address,
  input  logic        m0_rw,
  input  logic [1:0]  m0_byte_enable,
  input  logic [15:0] m0_write_data,
  output logic        m0_acknowledge,
  output logic [15:0] m0_read_data,

  input  logic        m1_bus_enable,
  input  logic [15:0] m1_address,
  input  logic        m1_rw,
  input  logic [1:0]  m1_byte_enable,
  input  logic [15:0] m1_write_data,
  output logic        m1_acknowledge,
  output logic [15:0] m1_read_data,

  output logic        io_bus_enable,
  output logic [15:0] io_address,
  output logic        io_rw,
  output logic [1:0]  io_byte_enable,
  output logic [15:0] io_write_data,
  input  logic        io_acknowledge,
  input  logic [15:0] io_read_data,

  input  logic        err_clear,
  output logic        err_timeout,
  output logic        grant_id
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             grant_q, grant_d;
  logic             io_en_q, io_en_d;
  logic [15:0]      io_addr_q, io_addr_d;
  logic             io_rw_q, io_rw_d;
  logic [1:0]       io_be_q, io_be_d;
  logic [15:0]      io_wdata_q, io_wdata_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic [15:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             err_q, err_d;

  logic             pick_valid, pick_winner;
  logic             finish_bus, timeout_set;
  logic [15:0]      resp_data;

  io_arb_rr_pick u_pick (
    .req        ({m1_bus_enable, m0_bus_enable}),
    .last_grant (grant_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    io_en_d     = io_en_q;
    io_addr_d   = io_addr_q;
    io_rw_d     = io_rw_q;
    io_be_d     = io_be_q;
    io_wdata_d  = io_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = '0;
    rdata1_d    = '0;
    cnt_inc     = cnt_q + CNT_W'(1);
    finish_bus  = 1'b0;
    timeout_set = 1'b0;
    resp_data   = '0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          grant_d    = pick_winner;
          io_en_d    = 1'b1;
          io_addr_d  = pick_winner ? m1_address     : m0_address;
          io_rw_d    = pick_winner ? m1_rw          : m0_rw;
          io_be_d    = pick_winner ? m1_byte_enable : m0_byte_enable;
          io_wdata_d = pick_winner ? m1_write_data  : m0_write_data;
          state_d    = ST_BUS;
        end
      end

      ST_BUS: begin
        cnt_d = cnt_inc;
        // Acknowledge is tested first so it wins over a same-cycle timeout.
        if (io_acknowledge) begin
          finish_bus = 1'b1;
          resp_data  = io_rw_q ? io_read_data : '0;
        end else if (cnt_inc == CNT_LIMIT) begin
          finish_bus  = 1'b1;
          timeout_set = 1'b1;
          resp_data   = io_rw_q ? ERR_READ_DATA : '0;
        end
        if (finish_bus) begin
          io_en_d = 1'b0;
          state_d = ST_RESP;
          // Acknowledge/read data are registered here so they appear in RESP.
          if (grant_q) begin
            ack1_d   = 1'b1;
            rdata1_d = resp_data;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = resp_data;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        io_en_d = 1'b0;
      end
    endcase

    if (timeout_set) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      grant_q    <= 1'b1;
      io_en_q    <= 1'b0;
      io_addr_q  <= '0;
      io_rw_q    <= 1'b0;
      io_be_q    <= '0;
      io_wdata_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      io_en_q    <= io_en_d;
      io_addr_q  <= io_addr_d;
      io_rw_q    <= io_rw_d;
      io_be_q    <= io_be_d;
      io_wdata_q <= io_wdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      err_q      <= err_d;
    end
  end

  assign io_bus_enable  = io_en_q;
  assign io_address     = io_addr_q;
  assign io_rw          = io_rw_q;
  assign io_byte_enable = io_be_q;
  assign io_write_data  = io_wdata_q;
  assign m0_acknowledge = ack0_q;
  assign m1_acknowledge = ack1_q;
  assign m0_read_data   = rdata0_q;
  assign m1_read_data   = rdata1_q;
  assign err_timeout    = err_q;
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] addr  [2];
  logic        rw    [2];
  logic [1:0]  be    [2];
  logic [15:0] wdata [2];

  logic        m0_acknowledge, m1_acknowledge;
  logic [15:0] m0_read_data, m1_read_data;
  logic        io_bus_enable, io_rw;
  logic [15:0] io_address, io_write_data;
  logic [1:0]  io_byte_enable;
  logic        io_acknowledge;
  logic [15:0] io_read_data;
  logic        err_clear, err_timeout, grant_id;

  int passes = 0;
  int total  = 0;

  // Transaction-level reference state
  int mdl_last;
  bit mdl_err;

  always #5 clk = ~clk;

  io_bus_arbiter #(.TIMEOUT_CYCLES(T), .ERR_READ_DATA(16'hDEAD)) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .m0_bus_enable  (req[0]),
    .m0_address     (addr[0]),
    .m0_rw          (rw[0]),
    .m0_byte_enable (be[0]),
    .m0_write_data  (wdata[0]),
    .m0_acknowledge (m0_acknowledge),
    .m0_read_data   (m0_read_data),
    .m1_bus_enable  (req[1]),
    .m1_address     (addr[1]),
    .m1_rw          (rw[1]),
    .m1_byte_enable (be[1]),
    .m1_write_data  (wdata[1]),
    .m1_acknowledge (m1_acknowledge),
    .m1_read_data   (m1_read_data),
    .io_bus_enable  (io_bus_enable),
    .io_address     (io_address),
    .io_rw          (io_rw),
    .io_byte_enable (io_byte_enable),
    .io_write_data  (io_write_data),
    .io_acknowledge (io_acknowledge),
    .io_read_data   (io_read_data),
    .err_clear      (err_clear),
    .err_timeout    (err_timeout),
    .grant_id       (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [15:0] a, input logic r,
                         input logic [1:0] b, input logic [15:0] d);
    addr[m] = a; rw[m] = r; be[m] = b; wdata[m] = d; req[m] = 1'b1;
  endtask

  task automatic rand_req(input int m);
    set_req(m, 16'($urandom), 1'($urandom), 2'($urandom), 16'($urandom));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    mdl_last = 1;
    mdl_err  = 1'b0;
  endtask

  // One full transaction from IDLE. dly = BUS cycle (1-based) in which the
  // slave acknowledges; 0 or > T means no acknowledge (timeout).
  // rearm: winner issues a new request right after its acknowledge.
  // clr_end: err_clear pulsed in the final BUS cycle.
  // clr_idle: err_clear pulsed during RESP.
  task automatic txn(input int dly, input bit rearm, input bit clr_end, input bit clr_idle);
    int          w;
    int          c;
    bit          acked;
    logic [15:0] sdata;
    logic [15:0] exp_rd;
    w = (req == 2'b11) ? 1 - mdl_last : (req[1] ? 1 : 0);
    tick;
    chk("bus_en_rise", io_bus_enable, 1);
    chk("grant", grant_id, w);
    chk("io_addr", io_address, addr[w]);
    chk("io_rw", io_rw, rw[w]);
    chk("io_be", io_byte_enable, be[w]);
    chk("io_wdata", io_write_data, wdata[w]);
    sdata = 16'($urandom);
    acked = 1'b0;
    for (c = 1; c <= T; c++) begin
      io_acknowledge = (c == dly);
      io_read_data   = (c == dly) ? sdata : 16'($urandom);
      err_clear      = clr_end && (c == dly || c == T);
      tick;
      io_acknowledge = 1'b0;
      err_clear      = 1'b0;
      if (c == dly) begin
        acked = 1'b1;
        break;
      end
      if (c < T) chk("bus_hold", {15'd0, io_bus_enable, io_address}, {15'd0, 1'b1, addr[w]});
    end
    if (!acked) mdl_err = 1'b1;
    else if (clr_end) mdl_err = 1'b0;
    exp_rd = rw[w] ? (acked ? sdata : 16'hDEAD) : 16'h0000;
    chk("resp_bus_en", io_bus_enable, 0);
    chk("resp_ack_win", (w == 1) ? m1_acknowledge : m0_acknowledge, 1);
    chk("resp_ack_other", (w == 1) ? m0_acknowledge : m1_acknowledge, 0);
    chk("resp_rdata_win", (w == 1) ? m1_read_data : m0_read_data, exp_rd);
    chk("resp_rdata_other", (w == 1) ? m0_read_data : m1_read_data, 0);
    chk("resp_err", err_timeout, mdl_err);
    mdl_last = w;
    if (rearm) rand_req(w);
    else req[w] = 1'b0;
    err_clear = clr_idle;
    tick;
    err_clear = 1'b0;
    if (clr_idle) mdl_err = 1'b0;
    chk("idle_bus_en", io_bus_enable, 0);
    chk("idle_acks", {m1_acknowledge, m0_acknowledge}, 0);
    chk("idle_err", err_timeout, mdl_err);
    chk("idle_grant", grant_id, mdl_last);
  endtask

  initial begin
    req = 2'b00;
    for (int m = 0; m < 2; m++) begin
      addr[m] = '0; rw[m] = 1'b0; be[m] = '0; wdata[m] = '0;
    end
    io_acknowledge = 1'b0;
    io_read_data   = '0;
    err_clear      = 1'b0;

    // Reset values
    do_reset;
    chk("rst_bus_en", io_bus_enable, 0);
    chk("rst_io_fields", {io_address, io_rw, io_byte_enable, io_write_data}, 0);
    chk("rst_acks", {m1_acknowledge, m0_acknowledge}, 0);
    chk("rst_rdata", {m1_read_data, m0_read_data}, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_grant", grant_id, 1);

    // m0 write, slave acknowledges in the second BUS cycle
    set_req(0, 16'h0010, 1'b0, 2'b11, 16'h1234);
    txn(2, 0, 0, 0);

    // Both masters held from reset: m0, m1, m0, m1
    do_reset;
    set_req(0, 16'h1000, 1'b1, 2'b01, 16'h0000);
    set_req(1, 16'h2000, 1'b0, 2'b10, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      chk("alt_expect", (req == 2'b11) ? 1 - mdl_last : 99, i % 2);
      txn(1, 1, 0, 0);
    end
    req = 2'b00;
    tick;

    // m1 read, no acknowledge: timeout with error data, then err_clear
    set_req(1, 16'h0200, 1'b1, 2'b11, 16'h0000);
    txn(0, 0, 0, 0);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    mdl_err = 1'b0;
    chk("err_cleared", err_timeout, 0);

    // Timeout setting in the same cycle as err_clear: set wins
    set_req(0, 16'h0300, 1'b1, 2'b01, 16'h0000);
    txn(0, 0, 1, 1);

    // Acknowledge in the cycle the counter reaches the limit
    set_req(0, 16'h0400, 1'b1, 2'b11, 16'h0000);
    txn(T, 0, 0, 0);

    // Spurious acknowledge while idle
    for (int i = 0; i < 3; i++) begin
      io_acknowledge = 1'b1;
      io_read_data   = 16'hBEEF;
      tick;
      chk("spur_bus_en", io_bus_enable, 0);
      chk("spur_acks", {m1_acknowledge, m0_acknowledge}, 0);
    end
    io_acknowledge = 1'b0;

    // Reset during the second BUS cycle, request still held afterwards
    set_req(0, 16'h0500, 1'b0, 2'b10, 16'hA5A5);
    tick;
    chk("abort_bus1", io_bus_enable, 1);
    tick;
    chk("abort_bus2", io_bus_enable, 1);
    rst = 1'b1;
    tick;
    chk("abort_bus_en", io_bus_enable, 0);
    chk("abort_acks", {m1_acknowledge, m0_acknowledge}, 0);
    chk("abort_grant", grant_id, 1);
    rst = 1'b0;
    mdl_last = 1;
    mdl_err  = 1'b0;
    txn(2, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      if (req == 2'b00 || $urandom_range(0, 1) == 1) begin
        for (int m = 0; m < 2; m++)
          if (!req[m] && $urandom_range(0, 1) == 1) rand_req(m);
        if (req == 2'b00) rand_req(int'($urandom_range(0, 1)));
      end
      txn(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for io_acknowledge (range 2..65535).
REQ-002 SHALL have parameter ERR_READ_DATA, default 16'hDEAD, returned on a timed-out read.
REQ-003 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset_reset  in  1  synchronous, active-high reset.
REQ-005 m0_bus_enable, m1_bus_enable  in  1  master request; held high until that master's acknowledge.
REQ-006 m0_address, m1_address  in  16  target address.
REQ-007 m0_rw, m1_rw  in  1  1=read, 0=write.
REQ-008 m0_byte_enable, m1_byte_enable  in  2  byte lanes.
REQ-009 m0_write_data, m1_write_data  in  16  write data.
REQ-010 m0_acknowledge, m1_acknowledge  out  1  one-cycle completion pulse.
REQ-011 m0_read_data, m1_read_data  out  16  read result; valid while the matching acknowledge is high.
REQ-012 io_bus_enable, io_address[16], io_rw, io_byte_enable[2], io_write_data[16]  out  shared external bus.
REQ-013 io_acknowledge  in  1; io_read_data  in  16  slave completion and data.
REQ-014 err_clear  in  1  clears err_timeout.
REQ-015 err_timeout  out  1  sticky timeout flag.
REQ-016 grant_id  out  1  owner of the current or last transaction.

Function
REQ-017 States SHALL be IDLE, BUS and RESP.
REQ-018 IDLE: if any request is high, latch the winner's address, rw, byte_enable and write_data, set grant_id, and go to BUS; otherwise stay.
REQ-019 Arbitration SHALL be round-robin: a single requester wins; on a tie the master not equal to last grant_id wins.
REQ-020 BUS: drive io_bus_enable=1 with latched fields held stable; the timeout counter SHALL increment each cycle.
REQ-021 io_acknowledge high in BUS SHALL capture io_read_data (reads only) and go to RESP.
REQ-022 If the counter reaches TIMEOUT_CYCLES without acknowledge: go to RESP, set err_timeout, and return ERR_READ_DATA on reads.
REQ-023 Acknowledge and timeout in the same cycle: acknowledge SHALL win and err_timeout SHALL not set.
REQ-024 RESP: io_bus_enable=0; the granted master's acknowledge=1 for exactly one cycle; go to IDLE.
REQ-025 Latency: request sampled at edge N -> io_bus_enable high from N+1; io_acknowledge sampled at edge K -> master acknowledge high in cycle K+1 -> IDLE at K+2; minimum 3 cycles per transaction.
REQ-026 io_bus_enable SHALL be low for at least one cycle (RESP) between consecutive transactions.
REQ-027 io_acknowledge seen outside BUS SHALL be ignored.
REQ-028 Requests arriving in BUS or RESP SHALL wait; no request is dropped while held high.
REQ-029 err_clear SHALL clear err_timeout unless a timeout is being set in the same cycle, in which case set wins.
REQ-030 The non-granted master's acknowledge SHALL be 0 and its read_data SHALL be 0.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 On reset the FSM SHALL return to IDLE from any state, including mid-BUS.
REQ-033 Reset values: io_bus_enable=0, all io_* outputs 0, both acknowledges 0, both read_data 0, err_timeout 0, counter 0, grant_id=1 (so m0 wins the first tie).
REQ-034 A transaction aborted by reset SHALL produce no master acknowledge.

Structure
REQ-035 Package io_arb_pkg SHALL hold the state enum, the TIMEOUT_CYCLES default and the ERR_READ_DATA default.
REQ-036 Sub-module io_arb_rr_pick SHALL be the combinational round-robin winner select (inputs: requests and last grant).
REQ-037 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-038 m0 write addr 16'h0010 data 16'h1234 be 2'b11, slave acks after 2 cycles -> io_* fields match; m0_acknowledge one cycle; m1_acknowledge 0.
REQ-039 m0 and m1 request together from reset, held continuously -> grants alternate m0, m1, m0, m1; io_bus_enable low one cycle between transactions.
REQ-040 m1 read addr 16'h0200 with no slave ack, TIMEOUT_CYCLES=4 -> m1_acknowledge after 4 BUS cycles, m1_read_data=16'hDEAD, err_timeout=1; err_clear pulse -> 0.
REQ-041 io_acknowledge in the same cycle the counter hits the limit -> real io_read_data returned; err_timeout stays 0.
REQ-042 reset_reset asserted in the second BUS cycle -> io_bus_enable 0 next cycle; no acknowledge; next request is served normally.
REQ-043 Spurious io_acknowledge in IDLE -> no state change and no acknowledge.
